// File: rtl/alu_pkg.sv
// Shared definitions for the execute/memory slice: ALUop values from main
// control, R-type funct codes, and the 4-bit ALU operation encodings.
package alu_pkg;

   // ALUop values produced by main control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // R-type funct field values understood by the decoder
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   // ALU operation encodings driven onto alu_control
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctrl_e;

   // True for operations whose carry flag comes from the subtractor
   function automatic logic uses_subtractor(input logic [3:0] ctl);
      return (ctl == ALU_SUB) || (ctl == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU-op decoder: maps main-control ALUop plus the R-type funct
// field onto a 4-bit ALU operation. Unknown funct codes fall back to ADD so
// the output is always a defined operation.
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control
);

   // Select the ALU operation from ALUop, consulting funct only for R-type
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_OR:  alu_control = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD, FUNCT_ADDU: alu_control = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: alu_control = ALU_SUB;
               FUNCT_AND:             alu_control = ALU_AND;
               FUNCT_OR:              alu_control = ALU_OR;
               FUNCT_XOR:             alu_control = ALU_XOR;
               FUNCT_NOR:             alu_control = ALU_NOR;
               FUNCT_SLT:             alu_control = ALU_SLT;
               default:               alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_dmem_unit.sv
// Execute/memory datapath slice: combinational 32-bit ALU with status flags
// and the word-addressed data memory used by lw/sw. Pipeline registers live
// outside; the only state here is the memory array, which SYS_reset clears
// asynchronously. Because the whole array must clear at once it is built
// from flops rather than a block RAM.
module alu_dmem_unit
   import alu_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int WIDTH      = 32
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [3:0]        alu_control,
   output logic [WIDTH-1:0]  result_out,
   output logic [3:0]        status_out,
   input  logic [31:0]       dmem_address,
   input  logic [WIDTH-1:0]  dmem_data_in,
   input  logic              dmem_mem_write,
   input  logic              dmem_mem_read,
   output logic [WIDTH-1:0]  dmem_data_out
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   alu_op_decoder u_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (alu_control)
   );

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_bit;
   logic             carry_flag;
   logic             ovf_flag;

   // Shared adder and subtractor; the subtractor's carry-out is "no borrow"
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
   assign slt_bit  = $signed(a) < $signed(b);

   // Select the ALU result and the arithmetic flags for the decoded operation
   always_comb begin
      result_out = '0;
      carry_flag = 1'b0;
      ovf_flag   = 1'b0;
      case (alu_control)
         ALU_AND: result_out = a & b;
         ALU_OR:  result_out = a | b;
         ALU_XOR: result_out = a ^ b;
         ALU_NOR: result_out = ~(a | b);
         ALU_ADD: begin
            result_out = sum_ext[WIDTH-1:0];
            carry_flag = sum_ext[WIDTH];
            ovf_flag   = add_ovf;
         end
         ALU_SUB: begin
            result_out = diff_ext[WIDTH-1:0];
            carry_flag = diff_ext[WIDTH];
            ovf_flag   = sub_ovf;
         end
         ALU_SLT: begin
            result_out = {{(WIDTH-1){1'b0}}, slt_bit};
            carry_flag = diff_ext[WIDTH];
         end
         default: result_out = '0;
      endcase
      if (!uses_subtractor(alu_control) && (alu_control != ALU_ADD)) begin
         carry_flag = 1'b0;
      end
   end

   assign status_out = {(result_out == '0), result_out[WIDTH-1], carry_flag, ovf_flag};

   // ------------------------------------------------------------------
   // Data memory
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]      mem_reg [DEPTH];
   logic [DEPTH_LOG2-1:0] mem_index;
   logic                  unused_addr_bits;

   // Word index: byte-offset bits dropped, upper bits ignored so accesses wrap
   assign mem_index        = dmem_address[DEPTH_LOG2+1:2];
   assign unused_addr_bits = ^{dmem_address[31:DEPTH_LOG2+2], dmem_address[1:0]};

   // Posedge write port; reset clears every word and blocks any write
   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (dmem_mem_write) begin
         mem_reg[mem_index] <= dmem_data_in;
      end
   end

   // Combinational read, gated to zero when no read is requested
   assign dmem_data_out = dmem_mem_read ? mem_reg[mem_index] : '0;

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Self-checking bench for alu_dmem_unit: directed scenarios plus randomized
// ALU and memory traffic checked against a behavioural model.
module tb_alu_dmem_unit;

   logic        SYS_clk;
   logic        SYS_reset;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_control;
   logic [31:0] result_out;
   logic [3:0]  status_out;
   logic [31:0] dmem_address;
   logic [31:0] dmem_data_in;
   logic        dmem_mem_write;
   logic        dmem_mem_read;
   logic [31:0] dmem_data_out;

   int vectors;
   int miscompares;

   logic [31:0] ref_mem [256];

   alu_dmem_unit #(.DEPTH_LOG2(8), .WIDTH(32)) dut (
      .SYS_clk        (SYS_clk),
      .SYS_reset      (SYS_reset),
      .alu_op         (alu_op),
      .funct          (funct),
      .a              (a),
      .b              (b),
      .alu_control    (alu_control),
      .result_out     (result_out),
      .status_out     (status_out),
      .dmem_address   (dmem_address),
      .dmem_data_in   (dmem_data_in),
      .dmem_mem_write (dmem_mem_write),
      .dmem_mem_read  (dmem_mem_read),
      .dmem_data_out  (dmem_data_out)
   );

   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural ALU: pick the operation from the instruction fields, then
   // evaluate it with plain wide signed/unsigned arithmetic.
   task automatic ref_alu(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          output logic [3:0] ctl, output logic [31:0] res,
                          output logic [3:0] st);
      string  kind;
      longint ux, uy, sx, sy, full;
      logic   cy, ov;
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (op == 2'b00)      kind = "add";
      else if (op == 2'b01) kind = "sub";
      else if (op == 2'b11) kind = "or";
      else begin
         case (f)
            6'h20, 6'h21: kind = "add";
            6'h22, 6'h23: kind = "sub";
            6'h24:        kind = "and";
            6'h25:        kind = "or";
            6'h26:        kind = "xor";
            6'h27:        kind = "nor";
            6'h2A:        kind = "slt";
            default:      kind = "add";
         endcase
      end
      cy = 1'b0;
      ov = 1'b0;
      ctl = 4'b0010;
      res = 32'h0;
      case (kind)
         "add": begin
            ctl  = 4'b0010;
            full = ux + uy;
            res  = full[31:0];
            cy   = (full >= 64'sd4294967296);
            ov   = ((sx + sy) > 64'sd2147483647) || ((sx + sy) < -64'sd2147483648);
         end
         "sub": begin
            ctl  = 4'b0110;
            full = ux - uy;
            res  = full[31:0];
            cy   = (ux >= uy);
            ov   = ((sx - sy) > 64'sd2147483647) || ((sx - sy) < -64'sd2147483648);
         end
         "slt": begin
            ctl = 4'b0111;
            res = (sx < sy) ? 32'd1 : 32'd0;
            cy  = (ux >= uy);
         end
         "and": begin ctl = 4'b0000; res = x & y;    end
         "or":  begin ctl = 4'b0001; res = x | y;    end
         "xor": begin ctl = 4'b0011; res = x ^ y;    end
         "nor": begin ctl = 4'b1100; res = ~(x | y); end
         default: ;
      endcase
      st = {(res == 32'h0), res[31], cy, ov};
   endtask

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr % 32'd1024) / 32'd4);
   endfunction

   task automatic test_reset();
      logic [31:0] addrs [3];
      addrs[0] = 32'd0;
      addrs[1] = 32'd4;
      addrs[2] = 32'd1020;
      SYS_reset = 1'b1;
      dmem_mem_read = 1'b1;
      #3;
      for (int i = 0; i < 3; i++) begin
         dmem_address = addrs[i];
         #1;
         vectors++;
         if (dmem_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read addr=%0d got=%h want=%h", addrs[i], dmem_data_out, 32'h0);
         end
      end
      // ALU has no state, so it keeps working while reset is high
      alu_op = 2'b00; a = 32'd3; b = 32'd4;
      #1;
      vectors++;
      if (result_out !== 32'd7) begin
         miscompares++;
         $display("FAIL reset_alu got=%h want=%h", result_out, 32'd7);
      end
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
   endtask

   task automatic test_rtype();
      logic [5:0]  fs   [5];
      logic [31:0] want [5];
      logic [3:0]  wctl [5];
      fs[0] = 6'h20; want[0] = 32'd12; wctl[0] = 4'b0010;
      fs[1] = 6'h22; want[1] = 32'd2;  wctl[1] = 4'b0110;
      fs[2] = 6'h24; want[2] = 32'd5;  wctl[2] = 4'b0000;
      fs[3] = 6'h25; want[3] = 32'd7;  wctl[3] = 4'b0001;
      fs[4] = 6'h2A; want[4] = 32'd0;  wctl[4] = 4'b0111;
      alu_op = 2'b10; a = 32'd7; b = 32'd5;
      for (int i = 0; i < 5; i++) begin
         funct = fs[i];
         #1;
         vectors++;
         if (result_out !== want[i] || alu_control !== wctl[i]) begin
            miscompares++;
            $display("FAIL rtype funct=%h got res=%h ctl=%b want res=%h ctl=%b",
                     fs[i], result_out, alu_control, want[i], wctl[i]);
         end
      end
      a = 32'hFFFF_FFFF; funct = 6'h2A;
      #1;
      vectors++;
      if (result_out !== 32'd1) begin
         miscompares++;
         $display("FAIL rtype_slt_neg got=%h want=%h", result_out, 32'd1);
      end
   endtask

   task automatic test_flags();
      alu_op = 2'b00; a = 32'h7FFF_FFFF; b = 32'd1;
      #1;
      vectors++;
      if (result_out !== 32'h8000_0000 || status_out !== 4'b0101) begin
         miscompares++;
         $display("FAIL flags_add_ovf got res=%h st=%b want res=%h st=%b",
                  result_out, status_out, 32'h8000_0000, 4'b0101);
      end
      alu_op = 2'b01; a = 32'd5; b = 32'd5;
      #1;
      vectors++;
      if (result_out !== 32'h0 || status_out !== 4'b1010) begin
         miscompares++;
         $display("FAIL flags_sub_zero got res=%h st=%b want res=%h st=%b",
                  result_out, status_out, 32'h0, 4'b1010);
      end
      alu_op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd1;
      #1;
      vectors++;
      if (result_out !== 32'h0 || status_out !== 4'b1010) begin
         miscompares++;
         $display("FAIL flags_add_carry got res=%h st=%b want res=%h st=%b",
                  result_out, status_out, 32'h0, 4'b1010);
      end
   endtask

   task automatic test_random_alu();
      logic [5:0]  flist [11];
      logic [31:0] specials [6];
      logic [3:0]  ectl, est;
      logic [31:0] eres;
      flist[0] = 6'h20; flist[1] = 6'h21; flist[2] = 6'h22; flist[3] = 6'h23;
      flist[4] = 6'h24; flist[5] = 6'h25; flist[6] = 6'h26; flist[7] = 6'h27;
      flist[8] = 6'h2A; flist[9] = 6'h00; flist[10] = 6'h3F;
      specials[0] = 32'h0;        specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h7FFF_FFFF; specials[3] = 32'h8000_0000;
      specials[4] = 32'd1;        specials[5] = 32'd5;
      for (int i = 0; i < 300; i++) begin
         alu_op = 2'($urandom_range(0, 3));
         funct  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flist[$urandom_range(0, 10)];
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         #1;
         ref_alu(alu_op, funct, a, b, ectl, eres, est);
         vectors++;
         if (alu_control !== ectl || result_out !== eres || status_out !== est) begin
            miscompares++;
            $display("FAIL alu_rand op=%b f=%h a=%h b=%h got ctl=%b res=%h st=%b want ctl=%b res=%h st=%b",
                     alu_op, funct, a, b, alu_control, result_out, status_out, ectl, eres, est);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] addrs [3];
      addrs[0] = 32'd8;
      addrs[1] = 32'd9;
      addrs[2] = 32'd1032;
      @(negedge SYS_clk);
      dmem_address = 32'd8; dmem_data_in = 32'hDEAD_BEEF;
      dmem_mem_write = 1'b1; dmem_mem_read = 1'b0;
      @(posedge SYS_clk);
      #1;
      ref_mem[word_of(32'd8)] = 32'hDEAD_BEEF;
      dmem_mem_write = 1'b0; dmem_mem_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dmem_address = addrs[i];
         #1;
         vectors++;
         if (dmem_data_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL store_load addr=%0d got=%h want=%h", addrs[i], dmem_data_out, 32'hDEAD_BEEF);
         end
      end
   endtask

   task automatic test_read_gating();
      @(negedge SYS_clk);
      dmem_address = 32'd8; dmem_mem_read = 1'b0; dmem_mem_write = 1'b0;
      dmem_data_in = 32'h1234_5678;
      #1;
      vectors++;
      if (dmem_data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL read_gate got=%h want=%h", dmem_data_out, 32'h0);
      end
      @(posedge SYS_clk);
      #1;
      dmem_mem_read = 1'b1;
      #1;
      vectors++;
      if (dmem_data_out !== ref_mem[word_of(32'd8)]) begin
         miscompares++;
         $display("FAIL write_gate got=%h want=%h", dmem_data_out, ref_mem[word_of(32'd8)]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = 32'd512;
      for (int i = 0; i < 16; i++) begin
         @(negedge SYS_clk);
         dmem_address   = base + 32'(4 * i);
         dmem_data_in   = $urandom;
         dmem_mem_write = 1'b1;
         dmem_mem_read  = 1'b0;
         @(posedge SYS_clk);
         ref_mem[word_of(dmem_address)] = dmem_data_in;
      end
      @(negedge SYS_clk);
      dmem_mem_write = 1'b0;
      dmem_mem_read  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         dmem_address = base + 32'(4 * i);
         #1;
         vectors++;
         if (dmem_data_out !== ref_mem[word_of(dmem_address)]) begin
            miscompares++;
            $display("FAIL b2b addr=%0d got=%h want=%h", dmem_address, dmem_data_out,
                     ref_mem[word_of(dmem_address)]);
         end
      end
   endtask

   task automatic test_random_mem();
      for (int i = 0; i < 400; i++) begin
         @(negedge SYS_clk);
         dmem_address   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         dmem_data_in   = $urandom;
         dmem_mem_write = ($urandom_range(0, 2) != 0);
         dmem_mem_read  = ($urandom_range(0, 3) != 0);
         #1;
         vectors++;
         if (dmem_data_out !== (dmem_mem_read ? ref_mem[word_of(dmem_address)] : 32'h0)) begin
            miscompares++;
            $display("FAIL mem_rand_pre addr=%h rd=%b got=%h want=%h", dmem_address, dmem_mem_read,
                     dmem_data_out, dmem_mem_read ? ref_mem[word_of(dmem_address)] : 32'h0);
         end
         @(posedge SYS_clk);
         if (dmem_mem_write) ref_mem[word_of(dmem_address)] = dmem_data_in;
         #1;
         vectors++;
         if (dmem_data_out !== (dmem_mem_read ? ref_mem[word_of(dmem_address)] : 32'h0)) begin
            miscompares++;
            $display("FAIL mem_rand_post addr=%h rd=%b wr=%b got=%h want=%h", dmem_address,
                     dmem_mem_read, dmem_mem_write, dmem_data_out,
                     dmem_mem_read ? ref_mem[word_of(dmem_address)] : 32'h0);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge SYS_clk);
      dmem_address = 32'd8; dmem_data_in = 32'hCAFE_F00D;
      dmem_mem_write = 1'b1; dmem_mem_read = 1'b1;
      @(posedge SYS_clk);
      #1;
      dmem_mem_write = 1'b0;
      #1;
      vectors++;
      if (dmem_data_out !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL async_pre got=%h want=%h", dmem_data_out, 32'hCAFE_F00D);
      end
      // Pulse reset between edges: memory must clear without any clock edge
      #1;
      SYS_reset = 1'b1;
      #1;
      vectors++;
      if (dmem_data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_clear got=%h want=%h", dmem_data_out, 32'h0);
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      // A write requested while reset is held must be discarded
      dmem_mem_write = 1'b1; dmem_data_in = 32'h5555_AAAA;
      @(posedge SYS_clk);
      #1;
      dmem_mem_write = 1'b0;
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      #1;
      vectors++;
      if (dmem_data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_write_blocked got=%h want=%h", dmem_data_out, 32'h0);
      end
      dmem_address = 32'd520;
      #1;
      vectors++;
      if (dmem_data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_other_word got=%h want=%h", dmem_data_out, 32'h0);
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      SYS_reset      = 1'b1;
      alu_op         = 2'b00;
      funct          = 6'h00;
      a              = 32'h0;
      b              = 32'h0;
      dmem_address   = 32'h0;
      dmem_data_in   = 32'h0;
      dmem_mem_write = 1'b0;
      dmem_mem_read  = 1'b0;
      test_reset();
      test_rtype();
      test_flags();
      test_random_alu();
      test_store_load();
      test_read_gating();
      test_back_to_back();
      test_random_mem();
      test_async_reset();
      test_random_mem();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_dmem_unit.md
Name: alu_dmem_unit

Overview:
- Execute/memory datapath slice of the 5-stage MIPS-style pipeline.
- Decodes ALUop/funct into a 4-bit ALU operation and performs the 32-bit ALU operation combinationally.
- Hosts the word-addressed data memory used by lw/sw.
- Pipeline registers (negedge-clocked) live outside this block. This block only adds the memory array state.

Parameters:
- DEPTH_LOG2, 8, log2 of data-memory word count (256 words = 1 KiB).
- WIDTH, 32, datapath and memory word width.

Ports:
- SYS_clk  input  1  system clock; memory write edge is posedge.
- SYS_reset  input  1  reset, asynchronous, active-high; clears the whole memory array.
- alu_op  input  2  ALUop from main control (EX_control_signal[5:4]).
- funct  input  6  instruction[5:0].
- a  input  32  operand 1 (rs value).
- b  input  32  operand 2 (rt value or sign-extended immediate).
- alu_control  output  4  decoded ALU operation (observable).
- result_out  output  32  ALU result.
- status_out  output  4  {zero, negative, carry, overflow}.
- dmem_address  input  32  byte address (MEM-stage ALU result).
- dmem_data_in  input  32  store data.
- dmem_mem_write  input  1  write enable.
- dmem_mem_read  input  1  read enable.
- dmem_data_out  output  32  read data.

Behaviour:
- ALU-op decode is purely combinational:
  - alu_op=00 → ADD (lw/sw/addi address calc).
  - alu_op=01 → SUB (beq/bne compare).
  - alu_op=11 → OR (ori).
  - alu_op=10 → funct decode:
    - 0x20/0x21 → ADD
    - 0x22/0x23 → SUB
    - 0x24 → AND
    - 0x25 → OR
    - 0x26 → XOR
    - 0x27 → NOR
    - 0x2A → SLT
    - any other funct → ADD (default, never X).
- alu_control encodings: AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110, SLT=0111, NOR=1100. Unused codes produce result 0.
- ALU is combinational, zero latency; result updates in the same delta as inputs.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - SLT is signed compare; result 1 or 0, zero-extended.
- status_out flags:
  - zero = (result_out==0).
  - negative = result_out[31].
  - carry = carry-out of ADD, or NOT borrow for SUB/SLT; 0 for logic ops.
  - overflow = signed overflow for ADD/SUB; 0 otherwise.
- Memory array: 2^DEPTH_LOG2 words, indexed by dmem_address[DEPTH_LOG2+1:2].
  - Bits [1:0] are ignored (accesses are word-aligned).
  - Upper bits are ignored, so addresses wrap modulo 1 KiB.
- Write: on posedge SYS_clk when dmem_mem_write=1, mem[index] <= dmem_data_in. No byte enables.
- Read: combinational. dmem_data_out = mem[index] when dmem_mem_read=1, else 32'h0.
- Read and write to the same word in the same cycle: read returns the old content until the posedge, then the new content (write-then-visible, no bypass).
- dmem_mem_read and dmem_mem_write both high is legal: the write is performed and the read behaves as above.
- Reset:
  - SYS_reset high asynchronously clears every memory word to 0.
  - Writes are blocked while reset is high.
  - Reset mid-operation discards any pending write.
  - ALU outputs have no state and are unaffected by reset.

Decomposition:
- Shared package alu_pkg holds:
  - ALUop constants (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10, ALUOP_OR=2'b11).
  - funct constants.
  - 4-bit alu_control codes.
- One natural sub-module: alu_op_decoder (alu_op, funct → alu_control).
- The ALU datapath and memory array stay in the top level.

Test Plan:
- Reset: assert SYS_reset; read addresses 0, 4 and 1020 with mem_read=1 → dmem_data_out = 0.
- R-type decode: alu_op=10 with a=7, b=5:
  - funct 0x20 → result 12.
  - funct 0x22 → result 2.
  - funct 0x24 → result 5.
  - funct 0x25 → result 7.
  - funct 0x2A → result 0.
  - With a=-1, funct 0x2A → result 1.
  - alu_control matches the encodings above.
- Flags:
  - ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow=1, negative=1.
  - SUB 5-5 (alu_op=01) → result 0, zero=1.
  - ADD 0xFFFFFFFF + 1 → carry=1, zero=1.
- Store/load: write 0xDEADBEEF at address 8 on a posedge; read address 8 → 0xDEADBEEF. Read address 9 → 0xDEADBEEF (low bits ignored). Read address 1032 → 0xDEADBEEF (wrap).
- Read gating: mem_read=0 at address 8 → 0; mem_write=0 on posedge → memory unchanged.
- Async reset after writes: pulse SYS_reset between clock edges → address 8 immediately reads 0.
